serial_add_arbiter: RTL and testbench

Bit-serial addition controller that time-shares one 1-bit full-adder slice between two requesters. Each granted request is processed LSB-first over WIDTH clock cycles, with a ripple carry held in a flop between bits. The requester receives a one-cycle acknowledge when the result is ready. The block sits between client logic and the single full-adder datapath, and replaces a parallel WIDTH-bit adder where area matters more than latency.

---
 rtl/serial_add_arbiter.sv | 179 +++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder sharing one full-adder slice between two requesters, LSB first.
// Optional SERIAL_ADD_SUB_EN adds per-requester subtract controls (sub0/sub1).
module serial_add_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub0,
  input  logic             sub1,
`endif
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic             r_prio;
  logic             r_win;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic             w_prio_nxt;
  logic             w_win_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_carry_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_cout_nxt;
  logic             w_ack0_nxt;
  logic             w_ack1_nxt;
  logic             w_busy_nxt;

  logic             w_grant1;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_sub;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last;

  // Requester 1 wins when alone or when both request and the pointer names it.
  assign w_grant1 = req1 & (~req0 | r_prio);
  assign w_op_a   = w_grant1 ? a1 : a0;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub    = w_grant1 ? sub1 : sub0;
`else
  assign w_sub    = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B at the grant and preset carry-in.
  assign w_op_b   = (w_grant1 ? b1 : b0) ^ {WIDTH{w_sub}};

  assign w_fa_s   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_fa_c   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_win_nxt   = r_win;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_win_nxt   = w_grant1;
          w_a_nxt     = w_op_a;
          w_b_nxt     = w_op_b;
          w_acc_nxt   = '0;
          w_carry_nxt = w_sub;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_a_nxt     = {1'b0, r_a[WIDTH-1:1]};
        w_b_nxt     = {1'b0, r_b[WIDTH-1:1]};
        w_acc_nxt   = {w_fa_s, r_acc[WIDTH-1:1]};
        w_carry_nxt = w_fa_c;
        w_cnt_nxt   = r_cnt + CW'(1);
        if (w_last) begin
          w_sum_nxt   = {w_fa_s, r_acc[WIDTH-1:1]};
          w_cout_nxt  = w_fa_c;
          w_ack0_nxt  = ~r_win;
          w_ack1_nxt  = r_win;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_prio_nxt  = ~r_win;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_win   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_win   <= w_win_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter (WIDTH=4); subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub0;
  logic             sub1;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
`ifdef SERIAL_ADD_SUB_EN
    .sub0  (sub0),
    .sub1  (sub1),
`endif
    .ack0  (ack0),
    .ack1  (ack1),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until either ack is high, bounded; returns the number of edges taken.
  task automatic wait_ack(output int n);
    n = 0;
    while (ack0 !== 1'b1 && ack1 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen;

    rst_n = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub0 = 1'b0; sub1 = 1'b0;
`endif
    step();
    step();
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    // 5 + 3 on requester 0
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd3;
    step();
    check("t1_busy_after_grant", 32'(busy), 32'd1);
    wait_ack(n);
    check("t1_latency", 32'(n), 32'd4);
    check("t1_ack0", 32'(ack0), 32'd1);
    check("t1_ack1", 32'(ack1), 32'd0);
    check("t1_sum",  32'(sum),  32'd8);
    check("t1_cout", 32'(cout), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd1);
    req0 = 1'b0;
    step();
    check("t1_ack0_pulse", 32'(ack0), 32'd0);
    check("t1_busy_idle",  32'(busy), 32'd0);

    // 15 + 1 on requester 1: wraps to 0 with carry
    req1 = 1'b1; a1 = 4'd15; b1 = 4'd1;
    step();
    wait_ack(n);
    check("t2_latency", 32'(n), 32'd4);
    check("t2_ack1", 32'(ack1), 32'd1);
    check("t2_ack0", 32'(ack0), 32'd0);
    check("t2_sum",  32'(sum),  32'd0);
    check("t2_cout", 32'(cout), 32'd1);
    req1 = 1'b0;
    step();
    step();
    step();
    check("t2_ack1_pulse", 32'(ack1), 32'd0);
    check("t2_sum_held",   32'(sum),  32'd0);
    check("t2_cout_held",  32'(cout), 32'd1);

    // Both requesting from reset: grants alternate 0,1,0 every 6 cycles
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd2; b1 = 4'd2;
    step();
    wait_ack(n);
    check("t3_first_latency", 32'(n), 32'd4);
    check("t3_ack0_a", 32'(ack0), 32'd1);
    check("t3_ack1_a", 32'(ack1), 32'd0);
    check("t3_sum_a",  32'(sum),  32'd2);
    step();
    wait_ack(n);
    check("t3_spacing_b", 32'(n + 1), 32'd6);
    check("t3_ack1_b", 32'(ack1), 32'd1);
    check("t3_ack0_b", 32'(ack0), 32'd0);
    check("t3_sum_b",  32'(sum),  32'd4);
    check("t3_cout_b", 32'(cout), 32'd0);
    step();
    wait_ack(n);
    check("t3_spacing_c", 32'(n + 1), 32'd6);
    check("t3_ack0_c", 32'(ack0), 32'd1);
    check("t3_sum_c",  32'(sum),  32'd2);
    req0 = 1'b0;
    req1 = 1'b0;
    step();

    // Reset during the third SHIFT cycle abandons the operation
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd2;
    step();
    step();
    step();
    rst_n = 1'b0;
    req0 = 1'b0;
    step();
    rst_n = 1'b1;
    check("t4_sum_rst",  32'(sum),  32'd0);
    check("t4_cout_rst", 32'(cout), 32'd0);
    check("t4_busy_rst", 32'(busy), 32'd0);
    check("t4_ack_rst",  32'({ack0, ack1}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | ack0 | ack1 | busy;
    end
    check("t4_no_ack_after_abort", 32'(seen), 32'd0);
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd7;
    step();
    wait_ack(n);
    check("t4_latency", 32'(n), 32'd4);
    check("t4_ack0", 32'(ack0), 32'd1);
    check("t4_sum",  32'(sum),  32'd14);
    check("t4_cout", 32'(cout), 32'd0);
    req0 = 1'b0;
    step();

    // Operands and req change after the grant; latched 10 + 6 is reported
    req0 = 1'b1; a0 = 4'd10; b0 = 4'd6;
    step();
    req0 = 1'b0; a0 = 4'd0; b0 = 4'd0;
    wait_ack(n);
    check("t5_latency", 32'(n), 32'd4);
    check("t5_ack0", 32'(ack0), 32'd1);
    check("t5_sum",  32'(sum),  32'd0);
    check("t5_cout", 32'(cout), 32'd1);
    step();

    // Pointer now favours requester 1, but a lone req0 still wins
    req0 = 1'b1; a0 = 4'd4; b0 = 4'd9;
    step();
    wait_ack(n);
    check("t6_ack0", 32'(ack0), 32'd1);
    check("t6_ack1", 32'(ack1), 32'd0);
    check("t6_sum",  32'(sum),  32'd13);
    check("t6_cout", 32'(cout), 32'd0);
    req0 = 1'b0;
    step();

`ifdef SERIAL_ADD_SUB_EN
    // 3 - 5 borrows; 9 - 4 does not
    req0 = 1'b1; sub0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    step();
    wait_ack(n);
    check("s1_ack0", 32'(ack0), 32'd1);
    check("s1_sum",  32'(sum),  32'd14);
    check("s1_cout", 32'(cout), 32'd0);
    req0 = 1'b0;
    step();
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd4;
    step();
    wait_ack(n);
    check("s2_ack0", 32'(ack0), 32'd1);
    check("s2_sum",  32'(sum),  32'd5);
    check("s2_cout", 32'(cout), 32'd1);
    req0 = 1'b0; sub0 = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
